// File: rtl/tdc_window_sequencer_if.sv
// Bundles the run-request/result handshake and the pulse-counter control
// lines of the TDC window sequencer into one port.
interface tdc_window_sequencer_if #(
    parameter int COUNT_W  = 7,
    parameter int NUM_MEAS = 4
);
    localparam int RESULT_W = COUNT_W + $clog2(NUM_MEAS);

    logic                start;
    logic                abort;
    logic [COUNT_W-1:0]  pulse_count;
    logic                pulse_counter_full;
    logic                clear;
    logic                en;
    logic                busy;
    logic                ready;
    logic                result_valid;
    logic [RESULT_W-1:0] result_sum;
    logic [COUNT_W-1:0]  result_avg;
    logic                overflow;

    modport master (
        output start, abort, pulse_count, pulse_counter_full,
        input  clear, en, busy, ready, result_valid, result_sum, result_avg, overflow
    );

    modport slave (
        input  start, abort, pulse_count, pulse_counter_full,
        output clear, en, busy, ready, result_valid, result_sum, result_avg, overflow
    );
endinterface

// File: rtl/tdc_window_sequencer.sv
// Opens NUM_MEAS fixed-length gate windows on the pulse counter, samples the
// count after each window and reports the sum and average of the samples.
module tdc_window_sequencer #(
    parameter int WINDOW_CYCLES = 16,
    parameter int COUNT_W       = 7,
    parameter int NUM_MEAS      = 4,
    parameter int RESULT_W      = COUNT_W + $clog2(NUM_MEAS)
) (
    input  logic                    clk,
    input  logic                    rst,
    tdc_window_sequencer_if.slave   bus
);
    localparam int AVG_SHIFT = $clog2(NUM_MEAS);
    localparam int IDX_W     = (NUM_MEAS > 1) ? $clog2(NUM_MEAS) : 1;
    localparam int TMR_W     = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MEASURE,
        LATCH,
        DONE
    } state_t;

    state_t              state;
    logic [RESULT_W-1:0] acc;
    logic [RESULT_W-1:0] sum_next;
    logic [IDX_W-1:0]    meas_idx;
    logic [TMR_W-1:0]    timer;
    logic                prev_overflow;

    // Running sum including the sample being latched this cycle; the counter
    // value is zero-extended so the accumulator can never wrap.
    assign sum_next = acc + RESULT_W'(bus.pulse_count);

    // Run sequencer: every output is a register updated alongside the state.
    // overflow is saved at run start so an aborted run can restore the value
    // reported by the last completed run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            acc              <= '0;
            meas_idx         <= '0;
            timer            <= '0;
            prev_overflow    <= 1'b0;
            bus.clear        <= 1'b0;
            bus.en           <= 1'b0;
            bus.busy         <= 1'b0;
            bus.ready        <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.result_sum   <= '0;
            bus.result_avg   <= '0;
            bus.overflow     <= 1'b0;
        end else begin
            bus.result_valid <= 1'b0;
            if (bus.abort && (state == CLEAR || state == MEASURE || state == LATCH)) begin
                state        <= IDLE;
                bus.clear    <= 1'b0;
                bus.en       <= 1'b0;
                bus.busy     <= 1'b0;
                bus.overflow <= prev_overflow;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (bus.start) begin
                            state         <= CLEAR;
                            acc           <= '0;
                            meas_idx      <= '0;
                            prev_overflow <= bus.overflow;
                            bus.overflow  <= 1'b0;
                            bus.ready     <= 1'b0;
                            bus.clear     <= 1'b1;
                            bus.en        <= 1'b0;
                            bus.busy      <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        state     <= MEASURE;
                        timer     <= '0;
                        bus.clear <= 1'b0;
                        bus.en    <= 1'b1;
                    end
                    MEASURE: begin
                        if (bus.pulse_counter_full || timer == TMR_W'(WINDOW_CYCLES - 1)) begin
                            state  <= LATCH;
                            bus.en <= 1'b0;
                            if (bus.pulse_counter_full) begin
                                bus.overflow <= 1'b1;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    LATCH: begin
                        acc      <= sum_next;
                        meas_idx <= meas_idx + 1'b1;
                        if (meas_idx == IDX_W'(NUM_MEAS - 1)) begin
                            state            <= DONE;
                            bus.result_sum   <= sum_next;
                            bus.result_avg   <= COUNT_W'(sum_next >> AVG_SHIFT);
                            bus.result_valid <= 1'b1;
                            bus.ready        <= 1'b1;
                            bus.busy         <= 1'b0;
                        end else begin
                            state     <= CLEAR;
                            bus.clear <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/tdc_window_sequencer.md
# tdc_window_sequencer

Measurement sequencer for the time-to-digital pulse-counting datapath. It drives the pulse counter's `clear` and `en` controls to open a fixed-length gate window of `WINDOW_CYCLES` clock cycles, then samples the counter. It repeats this for `NUM_MEAS` windows and accumulates the samples into a sum and an average. It sits beside the edge-detector/counter chain and returns the result to the top level with a `ready`/`result_valid` handshake.

## Interface
Parameters:
- `WINDOW_CYCLES`, 16: gate length in clk cycles per window; must be ≥1.
- `COUNT_W`, 7: width of the pulse-counter value.
- `NUM_MEAS`, 4: windows per run; must be a power of two, ≥1.
- `RESULT_W`, `COUNT_W + $clog2(NUM_MEAS)`: derived; sum width.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level-sampled request to begin a run.
- `abort`  in  1  cancel the current run.
- `pulse_count`  in  COUNT_W  current value of the pulse counter.
- `pulse_counter_full`  in  1  pulse counter has saturated.
- `clear`  out  1  synchronous clear to the pulse counter.
- `en`  out  1  pulse-counter enable (gate open).
- `busy`  out  1  a run is in progress.
- `ready`  out  1  result available; held high until the next accepted start.
- `result_valid`  out  1  one-cycle strobe on completion of a run.
- `result_sum`  out  RESULT_W  sum of the `NUM_MEAS` window counts.
- `result_avg`  out  COUNT_W  `result_sum >> $clog2(NUM_MEAS)` (truncated).
- `overflow`  out  1  sticky: some window in the last run saw `pulse_counter_full`.

## Operation
- States: IDLE, CLEAR, MEASURE, LATCH, DONE.
- IDLE / DONE:
  - `start`=1 → CLEAR; clear `acc`, `meas_idx`, `overflow`; drop `ready`.
  - Otherwise hold the current state.
- CLEAR (1 cycle):
  - `clear`=1, `en`=0; window timer reset to 0 → MEASURE.
- MEASURE:
  - `en`=1; the timer increments each cycle.
  - At timer = WINDOW_CYCLES-1 → LATCH.
  - If `pulse_counter_full`=1 → LATCH immediately and set `overflow` (sticky). A full flag on the final timer cycle has the same effect.
- LATCH (1 cycle):
  - `en`=0; `acc` += zero-extended `pulse_count`; `meas_idx`++.
  - If `meas_idx` was NUM_MEAS-1 → DONE; else → CLEAR.
- DONE entry:
  - `result_sum`←`acc` (including the final add); `result_avg` derived from it.
  - `result_valid`=1 for exactly that one cycle; `ready`=1 and held.
- `busy` = state ∉ {IDLE, DONE}.
- `abort`=1 in CLEAR/MEASURE/LATCH → IDLE on the next edge:
  - `en`=0; no `result_valid`; `ready` stays 0.
  - `result_sum`, `result_avg` and `overflow` keep their previous-run values.
- `abort` in IDLE/DONE is ignored. `abort` has priority over `start`.
- `start` while `busy` is ignored. `start` held high in DONE restarts immediately, giving back-to-back runs.
- Accumulator cannot wrap: max sum = NUM_MEAS·(2^COUNT_W−1), which fits in RESULT_W.

## Timing
- Reset values: state IDLE; all outputs 0.
- All outputs are registered or decoded from registered state; none depends combinationally on inputs.
- `start` high at edge 0:
  - CLEAR during cycle 1; MEASURE during cycles 2..WINDOW_CYCLES+1; LATCH during cycle WINDOW_CYCLES+2.
  - Each window lasts WINDOW_CYCLES+2 cycles.
  - DONE (`result_valid`) in cycle NUM_MEAS·(WINDOW_CYCLES+2)+1.
- `pulse_count` is sampled in LATCH, one cycle after `en` falls, so the counter's last increment is included.
- Async `rst` mid-run: everything returns to reset values immediately, including `result_sum`.

## Test plan
- **Reset:** assert `rst` with random inputs → all outputs 0; state IDLE; `start` ignored while `rst`=1.
- **Nominal run** (defaults; counter model yields 5 per window): `start` pulse → 4 `clear` pulses; `en` high 16 cycles each; `result_valid` in cycle 73; `result_sum`=20, `result_avg`=5, `overflow`=0, `ready`=1.
- **Saturation:** `pulse_counter_full` rises on the 3rd MEASURE cycle of window 2 → `en` drops after 3 cycles; run continues to 4 windows; `overflow`=1 until the next start.
- **Abort:** `abort` in window 3 MEASURE → IDLE next cycle; `en`=0; no `result_valid`; `result_sum` keeps the previous run's 20.
- **Start handling:** `start` during MEASURE → no effect on timing. `start` held through DONE → new run begins; `ready` falls the next cycle; back-to-back `result_valid` pulses 73 cycles apart.
- **Async reset mid-run:** `rst` asserted mid-LATCH between edges → outputs 0 before the next edge; clean run afterwards.
